// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the MEM stage load/store unit.
package mem_stage_lsu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_SIZE = 5;

  typedef enum logic [6:0] {
    OP_L    = 7'b0000011,
    OP_S    = 7'b0100011,
    OP_ALUI = 7'b0010011,
    OP_ALU  = 7'b0110011
  } opcode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    WAIT_R = 1'b1
  } lsu_state_e;

  typedef struct packed {
    logic                valid;
    opcode_e             opcode;
    logic [XLEN-1:0]     alu_result;
    logic [XLEN-1:0]     store_data;
    logic [REG_SIZE-1:0] rd;
    logic                reg_write;
  } ex_mem_t;

  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_L) || (op == OP_S);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid port between the LSU (master) and memory (slave).
interface mem_stage_lsu_if;

  logic                               req;
  logic                               we;
  logic [mem_stage_lsu_pkg::XLEN-1:0] addr;
  logic [mem_stage_lsu_pkg::XLEN-1:0] wdata;
  logic                               gnt;
  logic                               rvalid;
  logic [mem_stage_lsu_pkg::XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_stage_lsu_ex_mem_reg.sv
// EX_MEM pipeline register: holds while stalled, captures a bubble on flush or empty EX.
module mem_stage_lsu_ex_mem_reg
  import mem_stage_lsu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    stall_i,
  input  logic    flush_i,
  input  ex_mem_t ex_i,
  output ex_mem_t ex_mem_o
);

  ex_mem_t ex_mem_q;

  // Hold has priority, so a flush arriving while frozen is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q <= '0;
    end else if (!stall_i) begin
      if (flush_i || !ex_i.valid) begin
        ex_mem_q <= '0;
      end else begin
        ex_mem_q <= ex_i;
      end
    end
  end

  assign ex_mem_o = ex_mem_q;

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: EX_MEM register, word load/store sequencing on dmem, MEM_WB register.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  opcode_e             ex_opcode,
  input  logic [XLEN-1:0]     ex_alu_result,
  input  logic [XLEN-1:0]     ex_store_data,
  input  logic [REG_SIZE-1:0] ex_rd,
  input  logic                ex_reg_write,
  input  logic                flush,
  output logic                stall,
  output logic [XLEN-1:0]     ex_mem_fwd,
  mem_stage_lsu_if.master     dmem,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic [REG_SIZE-1:0] wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  ex_mem_t    ex_in, ex_mem_q;
  lsu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       mem_op, misal, is_load, is_store;
  logic       req_c, retire, ret_err;
  logic [XLEN-1:0] ret_data;

  logic                wb_valid_q, wb_reg_write_q, err_q;
  logic [REG_SIZE-1:0] wb_rd_q;
  logic [XLEN-1:0]     wb_data_q;

  always_comb begin
    ex_in            = '0;
    ex_in.valid      = ex_valid;
    ex_in.opcode     = ex_opcode;
    ex_in.alu_result = ex_alu_result;
    ex_in.store_data = ex_store_data;
    ex_in.rd         = ex_rd;
    ex_in.reg_write  = ex_reg_write;
  end

  mem_stage_lsu_ex_mem_reg u_ex_mem_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall_i  (stall),
    .flush_i  (flush),
    .ex_i     (ex_in),
    .ex_mem_o (ex_mem_q)
  );

  assign is_load  = (ex_mem_q.opcode == OP_L);
  assign is_store = (ex_mem_q.opcode == OP_S);
  assign mem_op   = ex_mem_q.valid && is_mem_op(ex_mem_q.opcode);
  assign misal    = mem_op && (ex_mem_q.alu_result[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall drops in the cycle an access finishes so EX_MEM refills on the retire edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    req_c    = 1'b0;
    retire   = 1'b0;
    ret_err  = 1'b0;
    ret_data = ex_mem_q.alu_result;
    unique case (state_q)
      IDLE: begin
        if (mem_op && !misal) begin
          req_c = 1'b1;
          if (dmem.gnt) begin
            if (is_load) begin
              state_d = WAIT_R;
              cnt_d   = '0;
              stall   = 1'b1;
            end else begin
              retire = 1'b1;
            end
          end else begin
            stall = 1'b1;
          end
        end else if (ex_mem_q.valid) begin
          retire  = 1'b1;
          ret_err = misal;
        end
      end
      WAIT_R: begin
        stall = 1'b1;
        if (dmem.rvalid) begin
          stall    = 1'b0;
          retire   = 1'b1;
          ret_data = dmem.rdata;
          state_d  = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          stall   = 1'b0;
          retire  = 1'b1;
          ret_err = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem.req   = req_c;
  assign dmem.we    = req_c && is_store;
  assign dmem.addr  = req_c ? ex_mem_q.alu_result : '0;
  assign dmem.wdata = (req_c && is_store) ? ex_mem_q.store_data : '0;

  // MEM_WB register; data/rd only move on retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      err_q          <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
    end else begin
      wb_valid_q     <= retire;
      wb_reg_write_q <= retire && ex_mem_q.reg_write && !is_store && !ret_err;
      err_q          <= retire && ret_err;
      if (retire) begin
        wb_rd_q   <= ex_mem_q.rd;
        wb_data_q <= ret_data;
      end
    end
  end

  assign ex_mem_fwd   = ex_mem_q.alu_result;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: single-cycle vector table plus multi-cycle load sequences.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  opcode_e     ex_opcode;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, flush;
  logic        stall, wb_valid, wb_reg_write, err;
  logic [31:0] ex_mem_fwd, wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int failures = 0;

  mem_stage_lsu_if dmem ();

  mem_stage_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .flush(flush), .stall(stall), .ex_mem_fwd(ex_mem_fwd),
    .dmem(dmem), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; opcode_e op; logic [31:0] alu; logic [31:0] sd; logic [4:0] rd;
    logic rw; logic fl; logic gnt;
    logic e_req; logic e_we; logic [31:0] e_addr; logic [31:0] e_wdata;
    logic e_wbv; logic e_wbrw; logic e_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_ex(input logic v, input opcode_e op, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                          input logic fl);
    ex_valid = v; ex_opcode = op; ex_alu_result = alu; ex_store_data = sd;
    ex_rd = rd; ex_reg_write = rw; flush = fl;
  endtask

  task automatic bubble();
    drive_ex(1'b0, OP_ALU, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic to_neg();
    @(negedge clk); #1;
  endtask

  task automatic to_pos();
    @(posedge clk); #1;
  endtask

  int stall_cnt;

  initial begin
    vecs[0] = '{1'b1, OP_ALU,  32'h1234,     32'h0,        5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, OP_S,    32'h100,      32'hDEADBEEF, 5'd2,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, OP_L,    32'h102,      32'h0,        5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, OP_S,    32'h201,      32'h55,       5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, OP_ALU,  32'h777,      32'h0,        5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, OP_S,    32'h300,      32'h99,       5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, OP_ALU,  32'hFFFFFFFC, 32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, OP_ALUI, 32'hA5A5,     32'h0,        5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    bubble();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 32'h0;
    #2;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req", 32'(dmem.req), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_fwd", ex_mem_fwd, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Table: one instruction at a time, EX_MEM checks then MEM_WB checks.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_ex(vecs[i].v, vecs[i].op, vecs[i].alu, vecs[i].sd, vecs[i].rd, vecs[i].rw, vecs[i].fl);
      dmem.gnt = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bubble();
      dmem.gnt = vecs[i].gnt;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'h0);
      chk($sformatf("v%0d_req", i), 32'(dmem.req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_we", i), 32'(dmem.we), 32'(vecs[i].e_we));
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_addr", i), dmem.addr, vecs[i].e_addr);
        chk($sformatf("v%0d_wdata", i), dmem.wdata, vecs[i].e_wdata);
      end
      if (vecs[i].v && !vecs[i].fl)
        chk($sformatf("v%0d_fwd", i), ex_mem_fwd, vecs[i].alu);
      to_pos();
      chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
      chk($sformatf("v%0d_wb_rw", i), 32'(wb_reg_write), 32'(vecs[i].e_wbrw));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
      if (vecs[i].e_wbv) begin
        chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].alu);
        chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
      end
    end

    // Load: gnt after two wait cycles, rvalid three cycles after gnt; next ALU op waits in EX.
    @(negedge clk);
    drive_ex(1'b1, OP_L, 32'h400, 32'h0, 5'd9, 1'b1, 1'b0);
    dmem.gnt = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_ex(1'b1, OP_ALU, 32'h55, 32'h0, 5'd4, 1'b1, 1'b0);
      dmem.gnt = (c == 2);
      #1;
      chk($sformatf("ld_req_c%0d", c), 32'(dmem.req), 32'h1);
      chk($sformatf("ld_addr_c%0d", c), dmem.addr, 32'h400);
      chk($sformatf("ld_we_c%0d", c), 32'(dmem.we), 32'h0);
      chk($sformatf("ld_stall_c%0d", c), 32'(stall), 32'h1);
    end
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      dmem.gnt = 1'b0;
      dmem.rvalid = (w == 2);
      dmem.rdata = (w == 2) ? 32'hCAFE0001 : 32'h0;
      #1;
      chk($sformatf("ld_wait_stall_w%0d", w), 32'(stall), (w == 2) ? 32'h0 : 32'h1);
      chk($sformatf("ld_wait_req_w%0d", w), 32'(dmem.req), 32'h0);
      chk($sformatf("ld_wait_fwd_w%0d", w), ex_mem_fwd, 32'h400);
    end
    to_pos();
    chk("ld_wb_valid", 32'(wb_valid), 32'h1);
    chk("ld_wb_data", wb_data, 32'hCAFE0001);
    chk("ld_wb_rd", 32'(wb_rd), 32'd9);
    chk("ld_wb_rw", 32'(wb_reg_write), 32'h1);
    chk("ld_err", 32'(err), 32'h0);
    @(negedge clk);
    dmem.rvalid = 1'b0;
    bubble();
    #1;
    chk("ld_next_fwd", ex_mem_fwd, 32'h55);
    chk("ld_next_stall", 32'(stall), 32'h0);
    to_pos();
    chk("ld_next_wb_data", wb_data, 32'h55);
    chk("ld_next_wb_rd", 32'(wb_rd), 32'd4);

    // Load timeout (TIMEOUT=4), late rvalid must not disturb the following ALU op.
    @(negedge clk);
    drive_ex(1'b1, OP_L, 32'h500, 32'h0, 5'd10, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_ex(1'b1, OP_ALU, 32'h66, 32'h0, 5'd11, 1'b1, 1'b0);
    dmem.gnt = 1'b1;
    #1;
    chk("to_req", 32'(dmem.req), 32'h1);
    chk("to_stall_gnt", 32'(stall), 32'h1);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      dmem.gnt = 1'b0;
      #1;
      chk($sformatf("to_stall_w%0d", w), 32'(stall), (w == 3) ? 32'h0 : 32'h1);
      @(posedge clk); #1;
      chk($sformatf("to_err_w%0d", w), 32'(err), (w == 3) ? 32'h1 : 32'h0);
    end
    chk("to_wb_valid", 32'(wb_valid), 32'h1);
    chk("to_wb_rw", 32'(wb_reg_write), 32'h0);
    chk("to_wb_rd", 32'(wb_rd), 32'd10);
    @(negedge clk);
    bubble();
    dmem.rvalid = 1'b1;
    dmem.rdata = 32'h00000BAD;
    #1;
    chk("to_late_stall", 32'(stall), 32'h0);
    chk("to_late_fwd", ex_mem_fwd, 32'h66);
    to_pos();
    chk("to_next_wb_data", wb_data, 32'h66);
    chk("to_next_wb_rw", 32'(wb_reg_write), 32'h1);
    chk("to_next_err", 32'(err), 32'h0);
    @(negedge clk);
    dmem.rvalid = 1'b0;

    // Best-case load: exactly one stall cycle.
    drive_ex(1'b1, OP_L, 32'h600, 32'h0, 5'd12, 1'b1, 1'b0);
    @(posedge clk);
    stall_cnt = 0;
    @(negedge clk);
    bubble();
    dmem.gnt = 1'b1;
    #1;
    if (stall) stall_cnt++;
    @(negedge clk);
    dmem.gnt = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata = 32'h12345678;
    #1;
    if (stall) stall_cnt++;
    chk("bc_stall_cycles", 32'(stall_cnt), 32'd1);
    to_pos();
    chk("bc_wb_data", wb_data, 32'h12345678);
    chk("bc_wb_valid", 32'(wb_valid), 32'h1);
    @(negedge clk);
    dmem.rvalid = 1'b0;

    // Reset asserted while waiting for rvalid.
    drive_ex(1'b1, OP_L, 32'h700, 32'h0, 5'd13, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bubble();
    dmem.gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem.gnt = 1'b0;
    #1;
    chk("rw_pre_stall", 32'(stall), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rw_rst_stall", 32'(stall), 32'h0);
    chk("rw_rst_req", 32'(dmem.req), 32'h0);
    chk("rw_rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rw_rst_wb_data", wb_data, 32'h0);
    chk("rw_rst_fwd", ex_mem_fwd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem.rvalid = 1'b1;
    dmem.rdata = 32'hBEEF;
    #1;
    chk("rw_post_stall", 32'(stall), 32'h0);
    to_pos();
    chk("rw_post_wb_valid", 32'(wb_valid), 32'h0);
    chk("rw_post_wb_data", wb_data, 32'h0);
    @(negedge clk);
    dmem.rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
